// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel center-aligned PWM with shared triangle carrier, valley-loaded duty and dead time
module pwm_multi_ch #(
  parameter int N_CH = 4,
  parameter int W = 8,
  parameter int DIV = 4,
  parameter int DT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_CH*(W+1)-1:0]  duty,
  input  logic                   duty_vld,
  input  logic [DT_W-1:0]        dead_time,
  output logic [N_CH-1:0]        pwm_h,
  output logic [N_CH-1:0]        pwm_l,
  output logic [W-1:0]           carrier,
  output logic                   sync,
  output logic                   upd_pend
);
  localparam int MAX = 2**W - 1;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [W:0] FULL = (W+1)'(2**W);
  logic [PW-1:0] pre;
  logic dir_up, tick, valley;
  logic [W-1:0] nxt;
  logic [N_CH*(W+1)-1:0] pending;
  always_comb begin
    tick = en && pre == PW'(DIV - 1);
    nxt = dir_up ? carrier + 1'b1 : carrier - 1'b1;
    valley = tick && nxt == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
      carrier <= '0;
      dir_up <= 1'b1;
      sync <= 1'b0;
      pending <= '0;
      upd_pend <= 1'b0;
    end else begin
      if (en) pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        carrier <= nxt;
        if (nxt == W'(MAX)) dir_up <= 1'b0;
        else if (nxt == '0) dir_up <= 1'b1;
      end
      sync <= valley;
      if (duty_vld) begin
        pending <= duty;
        upd_pend <= 1'b1;
      end else if (valley) upd_pend <= 1'b0;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [W:0] d, cmp;
    logic raw, raw_d, chg, open, h, l;
    logic [DT_W-1:0] dt_cnt;
    // open: the output matching raw may drive this edge (gap elapsed or no gap requested)
    always_comb begin
      d = pending[i*(W+1) +: W+1];
      chg = raw ^ raw_d;
      open = chg ? dead_time == '0 : dt_cnt <= DT_W'(1);
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        cmp <= '0;
        raw <= 1'b0;
        raw_d <= 1'b0;
        dt_cnt <= dead_time;
        h <= 1'b0;
        l <= 1'b0;
      end else begin
        if (valley) cmp <= d > FULL ? FULL : d;
        raw <= {1'b0, carrier} < cmp;
        raw_d <= raw;
        dt_cnt <= chg ? dead_time : dt_cnt > DT_W'(1) ? dt_cnt - 1'b1 : '0;
        h <= open & raw;
        l <= open & ~raw;
      end
    end
    assign pwm_h[i] = h;
    assign pwm_l[i] = l;
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: randomized scoreboard bench against an event-time reference model
module tb_pwm_multi_ch;
  localparam int N = 4, W = 8, DIV = 4, DT_W = 4, MAX = 255, PER = 2 * MAX;
  logic clk = 0, rst = 1, en = 0, duty_vld = 0;
  logic [N*(W+1)-1:0] duty = '0;
  logic [DT_W-1:0] dead_time = '0;
  logic [N-1:0] pwm_h, pwm_l;
  logic [W-1:0] carrier;
  logic sync, upd_pend;

  pwm_multi_ch #(.N_CH(N), .W(W), .DIV(DIV), .DT_W(DT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .duty(duty), .duty_vld(duty_vld),
    .dead_time(dead_time), .pwm_h(pwm_h), .pwm_l(pwm_l), .carrier(carrier),
    .sync(sync), .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] h, l;
    logic [W-1:0] c;
    logic s, u;
  } exp_t;
  exp_t q[$];
  exp_t mx, px;
  int checks = 0, errors = 0, cyc = 0;

  int en_cnt, car, pend[N], act[N], last_e[N], last_d[N];
  bit rc[N], rp[N], sy, up, valley, open;

  function automatic int tri_wave(int n);
    int p = n % PER;
    return p <= MAX ? p : PER - p;
  endfunction

  // Expected outputs for the cycle after each edge, from carrier tick counts and change times
  always @(posedge clk) begin
    mx = '0;
    if (rst) begin
      en_cnt = 0; car = 0; sy = 0; up = 0;
      for (int i = 0; i < N; i++) begin
        pend[i] = 0; act[i] = 0; rc[i] = 0; rp[i] = 0;
        last_e[i] = cyc; last_d[i] = int'(dead_time);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rc[i] != rp[i]) begin
          last_e[i] = cyc;
          last_d[i] = int'(dead_time);
        end
        open = cyc + 1 >= last_e[i] + 1 + last_d[i];
        mx.h[i] = open && rc[i];
        mx.l[i] = open && !rc[i];
        rp[i] = rc[i];
        rc[i] = car < act[i];
      end
      valley = 0;
      if (en) begin
        en_cnt++;
        if (en_cnt % DIV == 0) begin
          car = tri_wave(en_cnt / DIV);
          valley = car == 0;
        end
      end
      if (valley) for (int i = 0; i < N; i++) act[i] = pend[i] > 256 ? 256 : pend[i];
      if (duty_vld) begin
        for (int i = 0; i < N; i++) pend[i] = int'(duty[i*(W+1) +: W+1]);
        up = 1;
      end else if (valley) up = 0;
      sy = valley;
    end
    mx.c = W'(car);
    mx.s = sy;
    mx.u = up;
    q.push_back(mx);
    cyc++;
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      px = q.pop_front();
      chk("pwm_h", 32'(pwm_h), 32'(px.h));
      chk("pwm_l", 32'(pwm_l), 32'(px.l));
      chk("carrier", 32'(carrier), 32'(px.c));
      chk("sync", 32'(sync), 32'(px.s));
      chk("upd_pend", 32'(upd_pend), 32'(px.u));
      chk("no_overlap", 32'(pwm_h & pwm_l), 32'(0));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(int a, int b, int c, int d);
    duty[0*(W+1) +: W+1] = (W+1)'(a);
    duty[1*(W+1) +: W+1] = (W+1)'(b);
    duty[2*(W+1) +: W+1] = (W+1)'(c);
    duty[3*(W+1) +: W+1] = (W+1)'(d);
    duty_vld = 1;
    step(1);
    duty_vld = 0;
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 255;
      2: return 256;
      3: return 300 + $urandom_range(0, 211);
      default: return $urandom_range(0, 256);
    endcase
  endfunction

  initial begin
    dead_time = 2;
    step(3);
    rst = 0; en = 1;
    step(2100);
    dead_time = 0;
    load(128, 0, 0, 0);
    step(4200);
    step(700);
    load(128, 64, 256, 300);
    step(3000);
    dead_time = 3;
    step(4200);
    en = 0;
    step(100);
    en = 1;
    step(500);
    for (int k = 0; k < 20; k++) begin
      dead_time = DT_W'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) load(pick(), pick(), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        en = 0;
        step($urandom_range(1, 60));
        en = 1;
      end
      step($urandom_range(50, 1500));
    end
    step(1000);
    rst = 1;
    step(2);
    rst = 0;
    load(10, 250, 128, 0);
    step(3000);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
